// File: rtl/uart_fifo_ctrl.sv
// UART TX/RX FIFO controller: pointers, occupancy, flags, sticky overrun and
// 16550-style trigger level around a distributed dual-port RAM with async read.

module uart_raminfr #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [ADDR_WIDTH-1:0] dpra,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [DATA_WIDTH-1:0] dpo
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[a] <= di;
        end
    end

    // Async read gives show-ahead behaviour on the head word.
    assign dpo = r_mem[dpra];
endmodule

module uart_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    input  logic                  overrun_clr,
    input  logic [1:0]            trig_sel,
    output logic                  trig
);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_0    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LVL_1    = (ADDR_WIDTH+1)'(4);
    localparam logic [ADDR_WIDTH:0]   LVL_2    = (ADDR_WIDTH+1)'(8);
    localparam logic [ADDR_WIDTH:0]   LVL_3    = (ADDR_WIDTH+1)'(DEPTH-2);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overrun;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_we;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_level;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_FULL);
    assign count = r_count;
    assign overrun = r_overrun;

    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    // A flush suppresses the write and any overrun from a push in the same cycle.
    assign w_we      = w_push_ok & ~clear;
    assign w_drop    = push & ~w_push_ok & ~clear;

    always_comb begin
        w_level = LVL_0;
        case (trig_sel)
            2'd0:    w_level = LVL_0;
            2'd1:    w_level = LVL_1;
            2'd2:    w_level = LVL_2;
            default: w_level = LVL_3;
        endcase
    end

    assign trig = (r_count >= w_level);

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_ONE;
                else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_ONE;
            end
            // Set wins over clear when both happen in one cycle.
            if (w_drop)           r_overrun <= 1'b1;
            else if (overrun_clr) r_overrun <= 1'b0;
        end
    end

    uart_raminfr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk (clk),
        .we  (w_we),
        .a   (r_wr_ptr),
        .dpra(r_rd_ptr),
        .di  (din),
        .dpo (dout)
    );
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.

module tb_uart_fifo_ctrl;
    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       clear = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] trig_sel = 2'd3;
    logic [7:0] dout;
    logic [4:0] count;
    logic       empty, full, overrun, trig;

    int n_cmp = 0;
    int n_bad = 0;

    uart_fifo_ctrl dut (
        .clk        (clk),
        .nreset     (nreset),
        .clear      (clear),
        .push       (push),
        .din        (din),
        .pop        (pop),
        .dout       (dout),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .trig_sel   (trig_sel),
        .trig       (trig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is just a queue of at most 16 words.
    logic [7:0] mq[$];
    bit         m_ov;

    always @(posedge clk or posedge nreset) begin
        if (nreset) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            bit pop_ok, push_ok;
            pop_ok  = pop && (mq.size() > 0);
            push_ok = push && ((mq.size() < 16) || pop_ok);
            if (clear) begin
                mq.delete();
            end else begin
                if (pop_ok)  void'(mq.pop_front());
                if (push_ok) mq.push_back(din);
            end
            if (push && !push_ok && !clear) m_ov = 1'b1;
            else if (overrun_clr)           m_ov = 1'b0;
        end
    end

    always @(negedge clk) begin
        int sz, lvl;
        sz  = mq.size();
        lvl = (trig_sel == 2'd0) ? 1 : (trig_sel == 2'd1) ? 4 : (trig_sel == 2'd2) ? 8 : 14;
        chk("m_count", count, sz);
        chk("m_empty", empty, sz == 0);
        chk("m_full", full, sz == 16);
        chk("m_trig", trig, sz >= lvl);
        chk("m_overrun", overrun, m_ov);
        if (sz > 0) chk("m_dout", dout, mq[0]);
    end

    task automatic step(input bit pu, input bit po, input logic [7:0] d,
                        input bit cl = 1'b0, input bit oc = 1'b0);
        push = pu; pop = po; din = d; clear = cl; overrun_clr = oc;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0; overrun_clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_trig", trig, 0);
        chk("rst_overrun", overrun, 0);
        nreset = 1'b0;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            chk("fill_count", count, i + 1);
            if (i == 12) chk("fill_trig13", trig, 0);
            if (i == 13) chk("fill_trig14", trig, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_overrun", overrun, 0);

        // Overflow then drain
        step(1, 0, 8'hAA);
        chk("ovf_overrun", overrun, 1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", dout, i);
            step(0, 1, 8'h00);
            chk("drain_overrun", overrun, 1);
        end
        chk("drain_empty", empty, 1);
        step(0, 0, 8'h00, 0, 1);
        chk("ovclr", overrun, 0);

        // Full with simultaneous push+pop
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i));
        step(1, 1, 8'h55);
        chk("fpp_count", count, 16);
        chk("fpp_overrun", overrun, 0);
        chk("fpp_dout", dout, 8'h11);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00);
        chk("fpp_tail", dout, 8'h55);
        chk("fpp_tail_count", count, 1);
        step(0, 1, 8'h00);

        // Empty edge and wrap
        step(0, 1, 8'h00);
        chk("epop_count", count, 0);
        chk("epop_empty", empty, 1);
        step(1, 1, 8'h77);
        chk("epp_count", count, 1);
        chk("epp_dout", dout, 8'h77);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1, 0, 8'(8'hC0 + i));
            else            step(0, 1, 8'h00);
        end
        chk("wrap_count", count, 1);
        step(0, 1, 8'h00);

        // clear priority
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i));
        chk("clr_pre", count, 5);
        step(1, 1, 8'h99, 1, 0);
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_overrun", overrun, 0);
        step(1, 0, 8'h3C);
        chk("clr_push", dout, 8'h3C);

        // overrun_clr collision
        for (int i = 0; i < 15; i++) step(1, 0, 8'(i));
        chk("coll_full", full, 1);
        step(1, 0, 8'hEE, 0, 1);
        chk("coll_overrun", overrun, 1);
        step(0, 0, 8'h00, 0, 1);
        chk("coll_clr", overrun, 0);

        // Mid-operation reset, push accepted in the cycle reset deasserts
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_empty", empty, 1);
        nreset = 1'b0;
        step(1, 0, 8'h5A);
        chk("mrst_push", dout, 8'h5A);
        chk("mrst_count", count, 1);

        // Randomized traffic with varying push/pop bias
        for (int i = 0; i < 3000; i++) begin
            int ph;
            bit pu, po, cl, oc;
            ph = (i / 150) % 3;
            pu = ($urandom_range(0, 3) < ((ph == 0) ? 3 : (ph == 1) ? 2 : 1));
            po = ($urandom_range(0, 3) < ((ph == 0) ? 1 : (ph == 1) ? 2 : 3));
            cl = ($urandom_range(0, 63) == 0);
            oc = ($urandom_range(0, 7) == 0);
            trig_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                nreset = 1'b1;
                @(posedge clk); #1;
                nreset = 1'b0;
            end
            step(pu, po, 8'($urandom_range(0, 255)), cl, oc);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
